uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver; the downstream partner of the UART transmitter: consumes the serial tx line and delivers bytes.
//  Frame format is fixed to match the transmitter: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1), no parity.
//  Output is a byte plus a 1-cycle strobe with the same naming as the transmitter's parallel input, so a receiver can drive a transmitter directly.
// PARAMETERS
//  CLK_FREQ_KHz   50000   system clock frequency in kHz
//  BAUD_RATE_BPS  115200  line rate in bits/s
//  BIT_CLOCKS     derived (CLK_FREQ_KHz*1000)/BAUD_RATE_BPS; clocks per bit (434 at defaults); HALF_BIT = BIT_CLOCKS/2
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  rx         in   1  asynchronous serial input, idle high
//  data_en    out  1  1-cycle strobe: data holds a valid received byte
//  data       out  8  last correctly received byte; held until the next valid byte
//  rx_busy    out  1  high while a frame is in progress (any state except Idle)
//  frame_err  out  1  1-cycle strobe: stop bit sampled as 0
// BEHAVIOUR
//  Sync: rx passes through 2 flops (rx_s1, rx_s2; both reset to 1); all decisions use rx_s2 (2-cycle input latency).
//  Reset: data_en=0, frame_err=0, rx_busy=0, data=8'h00, status=Idle, bitClkCnt=0, dataBitCnt=0. Reset mid-frame aborts the frame; no strobe.
//  Counters: bitClkCnt width clog2(BIT_CLOCKS), wraps to 0 at each sample point; dataBitCnt 3 bits, 0..7.
//  data_en and frame_err default to 0 every cycle; each is high for exactly one cycle; never both high together.
//  FSM (one-hot, 5 states):
//   Idle:     bitClkCnt=0, dataBitCnt=0; rx_s2==0 -> StartBit.
//   StartBit: count to HALF_BIT-1; sample there: 1 -> false start, back to Idle (no strobe); 0 -> bitClkCnt=0, DataBits.
//   DataBits: count to BIT_CLOCKS-1; sample; shiftData <= {sample, shiftData[7:1]}; bitClkCnt=0;
//             dataBitCnt==7 -> dataBitCnt=0, StopBit; else dataBitCnt+1.
//   StopBit:  count to BIT_CLOCKS-1; sample: 1 -> data<=shiftData, data_en=1, Idle;
//             0 -> frame_err=1, data unchanged, BreakWait.
//   BreakWait: stay until rx_s2==1, then Idle. A held-low line (break) gives one frame_err, not a stream.
//  Sampling is mid-bit: the first data sample is HALF_BIT+BIT_CLOCKS clocks after the falling edge is seen on rx_s2.
//  Latency: data_en rises HALF_BIT + 9*BIT_CLOCKS (+ sync and FSM cycles, <=4) after the start edge on rx.
//  Back-to-back frames: Idle is re-entered mid-stop-bit, so the next start edge directly after the stop bit is caught.
//  rx_busy=0 only in Idle.
// CONFIGURATION
//  UART_RX_GLITCH_FILTER_EN defined: each sample (start, data, stop) is the 2-of-3 majority of rx_s2 over the last 3 clocks
//   at the sample point. Needs a 2-flop history, reset to 1.
//  Undefined: each sample is the single value of rx_s2 at the sample point. FSM and timing are the same in both builds.
// TESTING (CLK_FREQ_KHz=1000, BAUD_RATE_BPS=100000 -> BIT_CLOCKS=10, unless noted)
//  1 Byte 0xA5, correct frame -> exactly one data_en pulse, data=8'hA5, frame_err never high, rx_busy low afterwards.
//  2 rx low for 3 clocks, then high -> no data_en, no frame_err, FSM back in Idle before the HALF_BIT sample + 2 clocks.
//  3 Byte 0x3C with stop bit 0, rx held low 20 bits, then released -> one frame_err pulse, data keeps its previous value;
//    then byte 0x3C with a correct frame -> data_en, data=8'h3C.
//  4 0x00 then 0xFF back-to-back (one stop bit, no gap) -> two data_en pulses, values 8'h00 then 8'hFF.
//  5 rst asserted for 1 clock during data bit 4 -> outputs at reset values, no strobe; next byte 0x5A received correctly.
//  6 Loopback from the UART transmitter at default parameters, bytes 0x55, 0x01, 0x80 -> same bytes in order;
//    with UART_RX_GLITCH_FILTER_EN, a 1-clock low glitch at mid data bit still gives the correct byte.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. It pairs with the UART transmitter and uses the same parallel-side
// naming (data / data_en), so a receiver output can drive a transmitter input directly.
// Optional build macro: UART_RX_GLITCH_FILTER_EN. When it is defined, each bit decision is the
// 2-of-3 majority of the synchronised line over the last three clocks. When it is undefined, each
// bit decision is a single sample of the synchronised line. Timing and FSM are identical either way.
module uart_rx #(
    parameter int CLK_FREQ_KHz  = 50000,
    parameter int BAUD_RATE_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       data_en,
    output logic [7:0] data,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int BIT_CLOCKS = (CLK_FREQ_KHz * 1000) / BAUD_RATE_BPS;
    localparam int HALF_BIT   = BIT_CLOCKS / 2;
    localparam int CNT_W      = (BIT_CLOCKS > 2) ? $clog2(BIT_CLOCKS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLOCKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    // One-hot state encoding
    localparam logic [4:0] IDLE       = 5'b00001;
    localparam logic [4:0] START_BIT  = 5'b00010;
    localparam logic [4:0] DATA_BITS  = 5'b00100;
    localparam logic [4:0] STOP_BIT   = 5'b01000;
    localparam logic [4:0] BREAK_WAIT = 5'b10000;

    logic             rx_s1;
    logic             rx_s2;
    logic             sample;
    logic [4:0]       state;
    logic [CNT_W-1:0] bit_clk_cnt;
    logic [2:0]       data_bit_cnt;
    logic [7:0]       shift_data;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

`ifdef UART_RX_GLITCH_FILTER_EN
    logic [1:0] rx_hist;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Two previous synchronised values, so a one-clock spike is outvoted
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_s2};
        end
    end

    assign sample = majority3(rx_s2, rx_hist[0], rx_hist[1]);
`else
    assign sample = rx_s2;
`endif

    assign rx_busy = (state != IDLE);

    // Frame FSM: mid-bit sampling, byte assembly and the single-cycle output strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_clk_cnt  <= '0;
            data_bit_cnt <= '0;
            data         <= 8'h00;
            data_en      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            data_en   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_clk_cnt  <= '0;
                    data_bit_cnt <= '0;
                    if (!rx_s2) begin
                        state <= START_BIT;
                    end
                end
                START_BIT: begin
                    // Half a bit in, re-check the start bit; a high line means a false start
                    if (bit_clk_cnt == HALF_LAST) begin
                        bit_clk_cnt <= '0;
                        state       <= sample ? IDLE : DATA_BITS;
                    end else begin
                        bit_clk_cnt <= bit_clk_cnt + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (bit_clk_cnt == BIT_LAST) begin
                        bit_clk_cnt <= '0;
                        shift_data  <= {sample, shift_data[7:1]};
                        if (data_bit_cnt == 3'd7) begin
                            data_bit_cnt <= '0;
                            state        <= STOP_BIT;
                        end else begin
                            data_bit_cnt <= data_bit_cnt + 3'd1;
                        end
                    end else begin
                        bit_clk_cnt <= bit_clk_cnt + 1'b1;
                    end
                end
                STOP_BIT: begin
                    // Leaving mid stop bit lets a start edge right after the stop bit be caught
                    if (bit_clk_cnt == BIT_LAST) begin
                        bit_clk_cnt <= '0;
                        if (sample) begin
                            data    <= shift_data;
                            data_en <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK_WAIT;
                        end
                    end else begin
                        bit_clk_cnt <= bit_clk_cnt + 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    // A held-low line reports a single frame error, then waits for the line to idle
                    if (rx_s2) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. A small instance (BIT_CLOCKS=10) covers the
// frame-level scenarios. A default-parameter instance receives a modelled transmitter stream.
module tb_uart_rx;

    localparam int BC   = 10;   // 1000 kHz / 100000 bps
    localparam int HB   = BC / 2;
    localparam int BC_D = 434;  // 50000 kHz / 115200 bps

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_d = 1'b1;
    logic       data_en, rx_busy, frame_err;
    logic [7:0] data;
    logic       data_en_d, rx_busy_d, frame_err_d;
    logic [7:0] data_d;

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(100000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data_en(data_en), .data(data),
        .rx_busy(rx_busy), .frame_err(frame_err)
    );

    uart_rx dut_d (
        .clk(clk), .rst(rst), .rx(rx_d), .data_en(data_en_d), .data(data_d),
        .rx_busy(rx_busy_d), .frame_err(frame_err_d)
    );

    int tests = 0;
    int fails = 0;

    // Observations collected by the monitor; tests only read them
    logic [7:0] got_q[$];
    logic [7:0] got_d_q[$];
    int ferr_cnt = 0, ferr_d_cnt = 0, both_cnt = 0, wide_cnt = 0, busy_cnt = 0;
    int cyc = 0, en_cyc = 0;
    logic prev_en = 1'b0, prev_fe = 1'b0;
    logic [7:0] last_good = 8'h00;

    // Monitor: sample outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (data_en) begin
            got_q.push_back(data);
            en_cyc = cyc;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (data_en && frame_err) both_cnt = both_cnt + 1;
        if ((data_en && prev_en) || (frame_err && prev_fe)) wide_cnt = wide_cnt + 1;
        prev_en = data_en;
        prev_fe = frame_err;
        if (rx_busy) busy_cnt = busy_cnt + 1;
        if (data_en_d) got_d_q.push_back(data_d);
        if (frame_err_d) ferr_d_cnt = ferr_d_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx = v;
        else rx_d = v;
        tick(n);
    endtask

    // Reference transmitter: start 0, 8 bits LSB first, stop bit value as given
    task automatic send_frame(input int which, input logic [7:0] b, input logic stop_v, input int bc);
        drive(which, 1'b0, bc);
        for (int i = 0; i < 8; i++) drive(which, b[i], bc);
        drive(which, stop_v, bc);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        rx_d = 1'b1;
        tick(3);
        tests++; if (data_en !== 1'b0) begin fails++; $display("FAIL reset_data_en: got %b expected 0", data_en); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
        tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data); end
        tests++; if (rx_busy_d !== 1'b0 || data_d !== 8'h00) begin
            fails++; $display("FAIL reset_default_inst: busy %b data %h expected 0/00", rx_busy_d, data_d);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single_byte;
        int base, fe0, c0, lat;
        base = got_q.size();
        fe0 = ferr_cnt;
        c0 = cyc;
        send_frame(0, 8'hA5, 1'b1, BC);
        drive(0, 1'b1, 2 * BC);
        lat = en_cyc - c0;
        tests++; if (got_q.size() - base !== 1) begin fails++; $display("FAIL a5_count: got %0d expected 1", got_q.size() - base); end
        tests++; if (got_q.size() <= base || got_q[base] !== 8'hA5) begin
            fails++; $display("FAIL a5_value: got %h expected a5", (got_q.size() > base) ? got_q[base] : 8'hxx);
        end
        tests++; if (data !== 8'hA5) begin fails++; $display("FAIL a5_data_held: got %h expected a5", data); end
        tests++; if (ferr_cnt !== fe0) begin fails++; $display("FAIL a5_no_frame_err: got %0d expected %0d", ferr_cnt, fe0); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL a5_idle_after: got %b expected 0", rx_busy); end
        tests++; if (lat < HB + 9 * BC || lat > HB + 9 * BC + 5) begin
            fails++; $display("FAIL a5_latency: got %0d expected %0d..%0d", lat, HB + 9 * BC, HB + 9 * BC + 5);
        end
        last_good = 8'hA5;
    endtask

    task automatic test_false_start;
        int base, fe0, bz0;
        base = got_q.size();
        fe0 = ferr_cnt;
        bz0 = busy_cnt;
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 7);
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_back_idle: got %b expected 0", rx_busy); end
        drive(0, 1'b1, 2 * BC);
        tests++; if (busy_cnt <= bz0) begin fails++; $display("FAIL glitch_went_busy: got %0d busy cycles expected >0", busy_cnt - bz0); end
        tests++; if (got_q.size() !== base || ferr_cnt !== fe0) begin
            fails++; $display("FAIL glitch_no_strobe: got %0d bytes %0d errs expected 0/0", got_q.size() - base, ferr_cnt - fe0);
        end
    endtask

    task automatic test_frame_error;
        int base, fe0;
        logic [7:0] b;
        b = 8'h3C;
        base = got_q.size();
        fe0 = ferr_cnt;
        drive(0, 1'b0, BC);
        for (int i = 0; i < 8; i++) drive(0, b[i], BC);
        drive(0, 1'b0, 20 * BC);
        drive(0, 1'b1, 3 * BC);
        tests++; if (ferr_cnt - fe0 !== 1) begin fails++; $display("FAIL break_one_err: got %0d expected 1", ferr_cnt - fe0); end
        tests++; if (got_q.size() !== base) begin fails++; $display("FAIL break_no_data: got %0d expected 0", got_q.size() - base); end
        tests++; if (data !== last_good) begin fails++; $display("FAIL break_data_kept: got %h expected %h", data, last_good); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL break_idle_after: got %b expected 0", rx_busy); end
        send_frame(0, b, 1'b1, BC);
        drive(0, 1'b1, 2 * BC);
        tests++; if (got_q.size() <= base || got_q[base] !== b) begin
            fails++; $display("FAIL after_break_value: got %h expected %h", (got_q.size() > base) ? got_q[base] : 8'hxx, b);
        end
        tests++; if (data !== b) begin fails++; $display("FAIL after_break_data: got %h expected %h", data, b); end
        last_good = b;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        int base, fe0;
        base = got_q.size();
        fe0 = ferr_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        foreach (exp_q[i]) send_frame(0, exp_q[i], 1'b1, BC);
        drive(0, 1'b1, 2 * BC);
        tests++; if (got_q.size() - base !== exp_q.size()) begin
            fails++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            tests++; if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) begin
                fails++; $display("FAIL b2b_byte%0d: got %h expected %h", i, (base + i < got_q.size()) ? got_q[base + i] : 8'hxx, exp_q[i]);
            end
        end
        tests++; if (ferr_cnt !== fe0) begin fails++; $display("FAIL b2b_no_err: got %0d expected 0", ferr_cnt - fe0); end
        last_good = exp_q[exp_q.size() - 1];
    endtask

    task automatic test_reset_mid_frame;
        int base, fe0;
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        base = got_q.size();
        fe0 = ferr_cnt;
        drive(0, 1'b0, BC);
        for (int i = 0; i < 4; i++) drive(0, b[i], BC);
        drive(0, b[4], HB);
        rx = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++; if (data_en !== 1'b0 || frame_err !== 1'b0) begin
            fails++; $display("FAIL midrst_strobes: got en %b err %b expected 0/0", data_en, frame_err);
        end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", rx_busy); end
        tests++; if (data !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h expected 00", data); end
        drive(0, 1'b1, 3 * BC);
        tests++; if (got_q.size() !== base || ferr_cnt !== fe0) begin
            fails++; $display("FAIL midrst_no_strobe: got %0d bytes %0d errs expected 0/0", got_q.size() - base, ferr_cnt - fe0);
        end
        send_frame(0, 8'h5A, 1'b1, BC);
        drive(0, 1'b1, 2 * BC);
        tests++; if (got_q.size() <= base || got_q[base] !== 8'h5A) begin
            fails++; $display("FAIL midrst_next_byte: got %h expected 5a", (got_q.size() > base) ? got_q[base] : 8'hxx);
        end
        last_good = 8'h5A;
    endtask

    task automatic test_random_gaps;
        logic [7:0] exp_q[$];
        int base;
        base = got_q.size();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'($urandom_range(0, 255)));
            send_frame(0, exp_q[i], 1'b1, BC);
            drive(0, 1'b1, $urandom_range(0, 15));
        end
        drive(0, 1'b1, 2 * BC);
        tests++; if (got_q.size() - base !== 8) begin fails++; $display("FAIL rand_count: got %0d expected 8", got_q.size() - base); end
        foreach (exp_q[i]) begin
            tests++; if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) begin
                fails++; $display("FAIL rand_byte%0d: got %h expected %h", i, (base + i < got_q.size()) ? got_q[base + i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_loopback_default;
        logic [7:0] exp_q[$];
        int base;
        base = got_d_q.size();
        exp_q = '{8'h55, 8'h01, 8'h80};
        foreach (exp_q[i]) send_frame(1, exp_q[i], 1'b1, BC_D);
`ifdef UART_RX_GLITCH_FILTER_EN
        // 0xB7: bit 0 is high, and a one-clock low spike lands near its sample point
        exp_q.push_back(8'hB7);
        drive(1, 1'b0, BC_D);
        drive(1, 1'b1, 218);
        drive(1, 1'b0, 1);
        drive(1, 1'b1, BC_D - 219);
        for (int i = 1; i < 8; i++) drive(1, exp_q[3][i], BC_D);
        drive(1, 1'b1, BC_D);
`endif
        drive(1, 1'b1, 2 * BC_D);
        tests++; if (got_d_q.size() - base !== exp_q.size()) begin
            fails++; $display("FAIL loop_count: got %0d expected %0d", got_d_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            tests++; if (base + i >= got_d_q.size() || got_d_q[base + i] !== exp_q[i]) begin
                fails++; $display("FAIL loop_byte%0d: got %h expected %h", i, (base + i < got_d_q.size()) ? got_d_q[base + i] : 8'hxx, exp_q[i]);
            end
        end
        tests++; if (ferr_d_cnt !== 0) begin fails++; $display("FAIL loop_no_err: got %0d expected 0", ferr_d_cnt); end
    endtask

    task automatic test_strobe_rules;
        tests++; if (both_cnt !== 0) begin fails++; $display("FAIL strobes_exclusive: got %0d overlaps expected 0", both_cnt); end
        tests++; if (wide_cnt !== 0) begin fails++; $display("FAIL strobes_one_cycle: got %0d wide pulses expected 0", wide_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_gaps();
        test_loopback_default();
        test_strobe_rules();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
